// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit holding HI/LO; 34 cycles from accept to result.
// Build option: define MULDIV_SIGNED_EN to enable MULT/DIV (op[0]); otherwise every op is unsigned.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div_q;
    logic               dz_q;
    logic               done_q;
    logic               dbz_q;

    logic               accept;
    logic               is_div_d;
    logic               dz_d;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_d;

    // Handshake: start is taken on an edge where the FSM is IDLE or DONE; busy covers
    // accept through FIX/DONE, and done pulses for one cycle once hi/lo hold the result.
    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_div_d = op[1];
    assign dz_d     = op[1] && (b == '0);

`ifdef MULDIV_SIGNED_EN
    logic signed_op;
    logic neg_hi_d;
    logic neg_lo_d;
    logic neg_hi_q;
    logic neg_lo_q;

    assign signed_op = op[0];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    // Remainder follows the dividend; a zero divisor keeps the all-ones quotient.
    assign neg_hi_d  = signed_op && (is_div_d ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
    assign neg_lo_d  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) && !dz_d;
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign a_mag      = a;
    assign b_mag      = b;
`endif

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        step_d    = {mul_sum, acc_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!start) begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_RUN: begin
                    acc_q <= step_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
`ifdef MULDIV_SIGNED_EN
                    if (is_div_q) begin
                        if (neg_hi_q) acc_q[2*WIDTH-1:WIDTH] <= -acc_q[2*WIDTH-1:WIDTH];
                        if (neg_lo_q) acc_q[WIDTH-1:0] <= -acc_q[WIDTH-1:0];
                    end else if (neg_lo_q) begin
                        acc_q <= -acc_q;
                    end
`endif
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    hi_q    <= acc_q[2*WIDTH-1:WIDTH];
                    lo_q    <= acc_q[WIDTH-1:0];
                    done_q  <= 1'b1;
                    dbz_q   <= dz_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (accept) begin
                state_q  <= S_RUN;
                cnt_q    <= CW'(WIDTH - 1);
                acc_q    <= {{WIDTH{1'b0}}, a_mag};
                opnd_q   <= b_mag;
                is_div_q <= is_div_d;
                dz_q     <= dz_d;
`ifdef MULDIV_SIGNED_EN
                neg_hi_q <= neg_hi_d;
                neg_lo_q <= neg_lo_d;
`endif
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state   = state_q;

endmodule
